// File: rtl/meter_countdown_if.sv
// Interface for meter_countdown: divider levels, coin/preset pulses in; time and display state out.
interface meter_countdown_if;
  logic        clk_1Hz;
  logic        clk_blink;
  logic        add_60;
  logic        add_120;
  logic        set_15;
  logic        set_150;
  logic [13:0] seconds;
  logic [15:0] bcd;
  logic        display_on;
  logic        expired;

  modport master (
    output clk_1Hz, clk_blink, add_60, add_120, set_15, set_150,
    input  seconds, bcd, display_on, expired
  );

  modport slave (
    input  clk_1Hz, clk_blink, add_60, add_120, set_15, set_150,
    output seconds, bcd, display_on, expired
  );
endinterface

// File: rtl/meter_countdown.sv
// Parking-meter countdown: coin/preset handling, 1 Hz decrement, BCD and flash-controlled display enable.
// Define METER_SYNC_EN to put 2-flop synchronizers on clk_1Hz and clk_blink.
module meter_countdown #(
  parameter int MAX_TIME   = 9999,
  parameter int LOW_THRESH = 180
) (
  input  logic               clk,
  input  logic               rst,
  meter_countdown_if.slave   bus
);

  localparam logic [14:0] MAX_W = 15'(MAX_TIME);
  localparam logic [13:0] LOW_W = 14'(LOW_THRESH);

  logic        tick_lvl;
  logic        blink_lvl;
  logic        tick_prev_q;
  logic        tick;
  logic [13:0] seconds_q, seconds_d;
  logic [15:0] bcd_q, bcd_d;
  logic        expired_q, expired_d;
  logic        display_on_q, display_on_d;
  logic [14:0] dec;
  logic [14:0] add;
  logic [14:0] sum;

`ifdef METER_SYNC_EN
  // Synchronizers are deliberately not reset so edge tracking continues through rst.
  logic [1:0] sync_1hz_q;
  logic [1:0] sync_blink_q;

  always_ff @(posedge clk) begin
    sync_1hz_q   <= {sync_1hz_q[0], bus.clk_1Hz};
    sync_blink_q <= {sync_blink_q[0], bus.clk_blink};
  end

  assign tick_lvl  = sync_1hz_q[1];
  assign blink_lvl = sync_blink_q[1];
`else
  assign tick_lvl  = bus.clk_1Hz;
  assign blink_lvl = bus.clk_blink;
`endif

  function automatic logic [15:0] to_bcd(input logic [13:0] bin);
    logic [29:0] sh;
    sh = {16'd0, bin};
    for (int i = 0; i < 14; i++) begin
      for (int j = 0; j < 4; j++) begin
        if (sh[14 + 4*j +: 4] >= 4'd5)
          sh[14 + 4*j +: 4] = sh[14 + 4*j +: 4] + 4'd3;
      end
      sh = sh << 1;
    end
    return sh[29:14];
  endfunction

  always_comb begin
    tick = tick_lvl & ~tick_prev_q;

    dec = {1'b0, seconds_q};
    if (tick && (seconds_q != 14'd0))
      dec = dec - 15'd1;
    add = ({15{bus.add_60}} & 15'd60) + ({15{bus.add_120}} & 15'd120);
    sum = dec + add;

    seconds_d = seconds_q;
    if (bus.set_150)
      seconds_d = 14'd150;
    else if (bus.set_15)
      seconds_d = 14'd15;
    else if (sum > MAX_W)
      seconds_d = MAX_W[13:0];
    else
      seconds_d = sum[13:0];

    bcd_d     = to_bcd(seconds_q);
    expired_d = (seconds_q == 14'd0);

    // Low time flashes with the 1 Hz level; expired flashes with the blink level.
    display_on_d = 1'b1;
    if (seconds_q == 14'd0)
      display_on_d = blink_lvl;
    else if (seconds_q < LOW_W)
      display_on_d = tick_lvl;
  end

  always_ff @(posedge clk) begin
    tick_prev_q <= tick_lvl;
    if (rst) begin
      seconds_q    <= 14'd0;
      bcd_q        <= 16'd0;
      expired_q    <= 1'b0;
      display_on_q <= 1'b0;
    end else begin
      seconds_q    <= seconds_d;
      bcd_q        <= bcd_d;
      expired_q    <= expired_d;
      display_on_q <= display_on_d;
    end
  end

  assign bus.seconds    = seconds_q;
  assign bus.bcd        = bcd_q;
  assign bus.expired    = expired_q;
  assign bus.display_on = display_on_q;

endmodule

// File: doc/meter_countdown.md
# meter_countdown

Parking-meter time-keeping stage that sits directly downstream of the clock divider. Consumes the divider's 1 Hz square wave and blink square wave (both toggling levels in the `clk` domain), holds the remaining paid time, applies coin/preset pulses, and decrements once per second. Drives the 4-digit seven-segment driver with BCD digits and a display-enable that implements low-time and expired flashing.

## Interface

**Parameters**

- `MAX_TIME`, default 9999: saturation ceiling in seconds.
- `LOW_THRESH`, default 180: below this (and above 0), the display flashes at 1 Hz.

**Ports**

- `clk` in 1: system clock (100 MHz).
- `rst` in 1: reset, synchronous, active-high.
- `clk_1Hz` in 1: 1 Hz square-wave level from the divider; sampled in `clk` domain.
- `clk_blink` in 1: blink square-wave level from the divider; sampled in `clk` domain.
- `add_60` in 1: single-cycle pulse, add 60 s.
- `add_120` in 1: single-cycle pulse, add 120 s.
- `set_15` in 1: single-cycle pulse, load 15 s.
- `set_150` in 1: single-cycle pulse, load 150 s.
- `seconds` out 14: remaining time, binary, 0..`MAX_TIME`.
- `bcd` out 16: `seconds` as four BCD digits; [15:12] = thousands … [3:0] = ones.
- `display_on` out 1: 1 = segments lit, 0 = blanked.
- `expired` out 1: 1 when `seconds` == 0.

## Operation

- **Input staging.** `clk_1Hz` and `clk_blink` pass through the staging described under Configuration, producing `tick_lvl` and `blink_lvl`.
- **Tick detection.** `tick` = `tick_lvl` & ~`tick_prev`. `tick_prev` loads `tick_lvl` every cycle, including during `rst`, so no spurious tick is produced on the first cycle after reset.
- **Seconds update priority**, highest first:
  - `rst`: `seconds` = 0.
  - `set_150`: `seconds` = 150. If `set_15` is asserted in the same cycle, it is ignored.
  - `set_15`: `seconds` = 15.
  - Otherwise: `seconds` = min(`dec` + `add`, `MAX_TIME`).
    - `dec` = `seconds` − 1 if `tick` and `seconds` > 0, else `seconds`.
    - `add` = 60·`add_60` + 120·`add_120`; both asserted gives 180.
- A set pulse discards any coin or tick in the same cycle.
- Decrement saturates at 0 and never wraps.
- Internal sum width is at least 15 bits, so 9999 + 180 does not overflow before the clamp.
- **`bcd`.** Registered conversion of `seconds`; valid one cycle after `seconds` changes. Double-dabble, sequential or combinational, is an implementation choice provided the latency holds.
- **`expired`.** Registered: `seconds` == 0.
- **`display_on`.** Registered:
  - `seconds` ≥ `LOW_THRESH`: 1.
  - 0 < `seconds` < `LOW_THRESH`: `tick_lvl` (lit during the high half of each second).
  - `seconds` == 0: `blink_lvl`.

## Timing

- **Reset values.** All outputs 0, including `seconds`, `bcd`, `display_on` and `expired`. `expired` and `display_on` resume normal evaluation on the first cycle after `rst` deasserts.
- **Coin/set latency.** A pulse sampled at edge N is visible on `seconds` after edge N. `bcd`, `expired` and `display_on` follow after edge N+1.
- **Tick latency.**
  - With sync: a rising `clk_1Hz` first sampled at edge N decrements `seconds` after edge N+2.
  - Without sync: the decrement lands after edge N.
  - Exactly one decrement per `clk_1Hz` rising edge.
- **Reset mid-operation.** `rst` wins over every other input. Edge state is tracked through reset.
- **Back-to-back pulses.** Coin pulses on consecutive cycles each add. No pulse is dropped.

## Configuration

- **`METER_SYNC_EN`**
  - Defined: `clk_1Hz` and `clk_blink` each pass through a 2-flop synchronizer before `tick_lvl`/`blink_lvl`. This is the configuration for when the divider sits in another clock domain or behind a BUFG.
  - Undefined: `tick_lvl`/`blink_lvl` are the raw inputs, and the edge detector register is the only staging.
  - All other behaviour is identical between the two configurations, except the tick and flash latencies listed in Timing.

## Test plan

- **Reset and single coin:** reset, then one `add_60` pulse → `seconds`=60, `bcd`=16'h0060, `expired`=0, `display_on`=0 (flashing, since 60 < 180) while `clk_1Hz` is low.
- **Countdown to zero:** `set_15`, then 16 `clk_1Hz` rising edges → `seconds` reaches 0 after the 15th edge and stays 0. `expired`=1. `display_on` tracks `clk_blink`.
- **Saturation:** `seconds`=9950, then `add_60` and `add_120` together → `seconds`=9999. Additional coins keep 9999, and `bcd`=16'h9999.
- **Simultaneous events:**
  - `add_60` on the same cycle as a tick at `seconds`=100 → 159.
  - `set_15`+`set_150`+`add_60` together → 150.
- **Low-time threshold:** `seconds`=181 with ticks → `display_on`=1 at 181 and 180. At 179, `display_on` equals `clk_1Hz`.
- **Reset mid-count:** `seconds`=500 with `clk_1Hz` held high through a reset → all outputs 0, and no decrement or tick on release. Repeat with `METER_SYNC_EN` both defined and undefined, checking the 3-edge vs 1-edge tick latency.
